// File: rtl/pb_intc_pkg.sv
// Shared constants for the PicoBlaze interrupt controller: register offsets,
// CTRL/VECTOR bit positions and the source-count ceiling.
package pb_intc_pkg;

  localparam int MAX_SOURCES = 16;

  // Register offsets within the 16-byte window
  localparam logic [3:0] OFF_STATUS_LO  = 4'h0;
  localparam logic [3:0] OFF_STATUS_HI  = 4'h1;
  localparam logic [3:0] OFF_ENABLE_LO  = 4'h2;
  localparam logic [3:0] OFF_ENABLE_HI  = 4'h3;
  localparam logic [3:0] OFF_PENDING_LO = 4'h4;
  localparam logic [3:0] OFF_PENDING_HI = 4'h5;
  localparam logic [3:0] OFF_MODE_LO    = 4'h6;
  localparam logic [3:0] OFF_MODE_HI    = 4'h7;
  localparam logic [3:0] OFF_VECTOR     = 4'h8;
  localparam logic [3:0] OFF_CTRL       = 4'h9;

  // CTRL register layout
  localparam int CTRL_W      = 2;
  localparam int GIE_BIT     = 0;
  localparam int ACK_CLR_BIT = 1;

  // VECTOR register valid flag position
  localparam int VEC_VALID_BIT = 7;

  // Mask with one bit set for every implemented source
  function automatic logic [MAX_SOURCES-1:0] src_mask(input int n);
    return 16'((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/pb_intc_prio_enc.sv
// Lowest-index-first priority encoder over the 16 possible sources.
module pb_intc_prio_enc
  import pb_intc_pkg::*;
(
  input  logic [MAX_SOURCES-1:0] req_i,
  output logic                   valid_o,
  output logic [3:0]             id_o
);

  // Scan upward; the first set bit found wins
  always_comb begin
    valid_o = 1'b0;
    id_o    = 4'h0;
    for (int i = 0; i < MAX_SOURCES; i++) begin
      if (!valid_o && req_i[i]) begin
        valid_o = 1'b1;
        id_o    = 4'(i);
      end else begin
        id_o    = id_o;
      end
    end
  end

endmodule

// File: rtl/pb_intc.sv
// PicoBlaze interrupt controller: per-source mask, pending latch and
// level/rising-edge mode, fixed-priority vector, single CPU interrupt line.
module pb_intc
  import pb_intc_pkg::*;
#(
  parameter logic [7:0] BASE_ADDRESS = 8'h80,
  parameter int         NUM_SOURCES  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             port_id,
  input  logic [7:0]             data_in,
  input  logic                   read_strobe,
  input  logic                   write_strobe,
  input  logic [NUM_SOURCES-1:0] irq_src,
  input  logic                   interrupt_ack,
  output logic [7:0]             data_out,
  output logic                   interrupt
);

  localparam logic [MAX_SOURCES-1:0] SRC_MASK = src_mask(NUM_SOURCES);

  logic [MAX_SOURCES-1:0] enable_q, enable_d;
  logic [MAX_SOURCES-1:0] pending_q, pending_d;
  logic [MAX_SOURCES-1:0] mode_q, mode_d;
  logic [MAX_SOURCES-1:0] src_q;
  logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
  logic                   interrupt_q, interrupt_d;
  logic [7:0]             data_out_q, data_out_d;

  logic [MAX_SOURCES-1:0] irq_ext_s, set_s, status_s, w1c_s, ack_clr_s;
  logic                   sel_s, wr_s, vec_valid_s;
  logic [3:0]             off_s, vec_id_s;
  logic [7:0]             rd_data_s;
  logic                   unused_s;

  // The read mux is refreshed every cycle, so the strobe itself is not needed
  assign unused_s  = read_strobe;

  assign irq_ext_s = 16'(irq_src);
  assign sel_s     = (port_id[7:4] == BASE_ADDRESS[7:4]);
  assign off_s     = port_id[3:0];
  assign wr_s      = write_strobe & sel_s;
  assign status_s  = pending_q & enable_q;

  pb_intc_prio_enc u_prio_enc (
    .req_i   (status_s),
    .valid_o (vec_valid_s),
    .id_o    (vec_id_s)
  );

  // Set requests: level sources follow the input, edge sources fire on 0->1
  always_comb begin
    set_s = ((mode_q & irq_ext_s & ~src_q) | (~mode_q & irq_ext_s)) & SRC_MASK;
  end

  // Register writes and write-1-to-clear decode
  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    ctrl_d   = ctrl_q;
    w1c_s    = 16'h0000;
    if (wr_s) begin
      case (off_s)
        OFF_ENABLE_LO:  enable_d[7:0]  = data_in;
        OFF_ENABLE_HI:  enable_d[15:8] = data_in;
        OFF_PENDING_LO: w1c_s[7:0]     = data_in;
        OFF_PENDING_HI: w1c_s[15:8]    = data_in;
        OFF_MODE_LO:    mode_d[7:0]    = data_in;
        OFF_MODE_HI:    mode_d[15:8]   = data_in;
        OFF_CTRL:       ctrl_d         = data_in[CTRL_W-1:0];
        default:        w1c_s          = 16'h0000;
      endcase
    end else begin
      w1c_s = 16'h0000;
    end
    enable_d = enable_d & SRC_MASK;
    mode_d   = mode_d & SRC_MASK;
  end

  // Pending update: a set beats any clear; clears from W1C and ack combine
  always_comb begin
    if (interrupt_ack && ctrl_q[ACK_CLR_BIT] && vec_valid_s) begin
      ack_clr_s = 16'h0001 << vec_id_s;
    end else begin
      ack_clr_s = 16'h0000;
    end
    pending_d   = (set_s | (pending_q & ~(w1c_s | ack_clr_s))) & SRC_MASK;
    interrupt_d = ctrl_q[GIE_BIT] & (|status_s);
  end

  // Read mux; unmapped offsets and foreign addresses return zero
  always_comb begin
    rd_data_s = 8'h00;
    case (off_s)
      OFF_STATUS_LO:  rd_data_s = status_s[7:0];
      OFF_STATUS_HI:  rd_data_s = status_s[15:8];
      OFF_ENABLE_LO:  rd_data_s = enable_q[7:0];
      OFF_ENABLE_HI:  rd_data_s = enable_q[15:8];
      OFF_PENDING_LO: rd_data_s = pending_q[7:0];
      OFF_PENDING_HI: rd_data_s = pending_q[15:8];
      OFF_MODE_LO:    rd_data_s = mode_q[7:0];
      OFF_MODE_HI:    rd_data_s = mode_q[15:8];
      OFF_VECTOR: begin
        if (vec_valid_s) begin
          rd_data_s[VEC_VALID_BIT] = 1'b1;
          rd_data_s[3:0]           = vec_id_s;
        end else begin
          rd_data_s = 8'h00;
        end
      end
      OFF_CTRL:       rd_data_s[CTRL_W-1:0] = ctrl_q;
      default:        rd_data_s = 8'h00;
    endcase
    if (sel_s) begin
      data_out_d = rd_data_s;
    end else begin
      data_out_d = 8'h00;
    end
  end

  // State registers; the source history tracks the input even in reset so a
  // source already high at release does not count as an edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      enable_q    <= 16'h0000;
      pending_q   <= 16'h0000;
      mode_q      <= 16'h0000;
      ctrl_q      <= 2'b00;
      interrupt_q <= 1'b0;
      data_out_q  <= 8'h00;
      src_q       <= irq_ext_s;
    end else begin
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      mode_q      <= mode_d;
      ctrl_q      <= ctrl_d;
      interrupt_q <= interrupt_d;
      data_out_q  <= data_out_d;
      src_q       <= irq_ext_s;
    end
  end

  assign data_out  = data_out_q;
  assign interrupt = interrupt_q;

endmodule

// File: tb/tb_pb_intc.sv
// Scoreboard bench for pb_intc (12 sources at base 0x80): directed scenarios
// followed by randomized bus/IRQ traffic checked against a behavioural model.
module tb_pb_intc;

  localparam int         NS  = 12;
  localparam logic [15:0] MSK = 16'h0FFF;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    port_id, data_in, data_out;
  logic          read_strobe, write_strobe, interrupt_ack, interrupt;
  logic [NS-1:0] irq_src;

  int total = 0;
  int bad   = 0;

  pb_intc #(.BASE_ADDRESS(8'h80), .NUM_SOURCES(NS)) dut (
    .clk           (clk),
    .reset         (reset),
    .port_id       (port_id),
    .data_in       (data_in),
    .read_strobe   (read_strobe),
    .write_strobe  (write_strobe),
    .irq_src       (irq_src),
    .interrupt_ack (interrupt_ack),
    .data_out      (data_out),
    .interrupt     (interrupt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [15:0] en;
    logic [15:0] pend;
    logic [15:0] mode;
    logic [15:0] prev;
    logic [1:0]  ctrl;
    logic        intr;
  } mstate_t;

  typedef struct packed {
    logic [7:0] exp;
    logic       has_c;
    logic [7:0] c;
    logic [7:0] pid;
  } rd_t;

  mstate_t ms = '0;
  rd_t     rq[$];
  logic    rd_flag = 1'b0;
  logic    cur_has_c = 1'b0;
  logic [7:0] cur_c = 8'h00;

  function automatic int lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] m_read(input mstate_t s, input logic [7:0] pid);
    logic [15:0] st;
    int lid;
    st  = s.pend & s.en;
    lid = lowest(st);
    if (pid[7:4] != 4'h8) return 8'h00;
    case (pid[3:0])
      4'h0: return st[7:0];
      4'h1: return st[15:8];
      4'h2: return s.en[7:0];
      4'h3: return s.en[15:8];
      4'h4: return s.pend[7:0];
      4'h5: return s.pend[15:8];
      4'h6: return s.mode[7:0];
      4'h7: return s.mode[15:8];
      4'h8: return (lid < 0) ? 8'h00 : 8'(128 + lid);
      4'h9: return {6'b000000, s.ctrl};
      default: return 8'h00;
    endcase
  endfunction

  function automatic mstate_t m_next(input mstate_t s, input logic rst_n,
                                     input logic [7:0] pid, input logic [7:0] din,
                                     input logic wr, input logic ack,
                                     input logic [NS-1:0] irq);
    mstate_t n;
    int lid;
    logic w, rise, clr;
    n = s;
    if (!rst_n) begin
      n = '0;
      n.prev = 16'(irq);
      return n;
    end
    lid = lowest(s.pend & s.en);
    w   = wr && (pid[7:4] == 4'h8);
    for (int i = 0; i < NS; i++) begin
      rise = s.mode[i] ? (irq[i] && !s.prev[i]) : irq[i];
      clr  = 1'b0;
      if (w && pid[3:0] == 4'h4 && i < 8 && din[i % 8]) clr = 1'b1;
      if (w && pid[3:0] == 4'h5 && i >= 8 && din[i % 8]) clr = 1'b1;
      if (ack && s.ctrl[1] && lid == i) clr = 1'b1;
      n.pend[i] = rise ? 1'b1 : (clr ? 1'b0 : s.pend[i]);
      n.prev[i] = irq[i];
    end
    if (w) begin
      case (pid[3:0])
        4'h2: n.en[7:0]    = din;
        4'h3: n.en[15:8]   = din;
        4'h6: n.mode[7:0]  = din;
        4'h7: n.mode[15:8] = din;
        4'h9: n.ctrl       = din[1:0];
        default: ;
      endcase
    end
    n.en   = n.en & MSK;
    n.mode = n.mode & MSK;
    n.intr = s.ctrl[0] && ((s.pend & s.en) != 16'h0000);
    return n;
  endfunction

  // Model advance and scoreboard push at each active edge
  always @(posedge clk) begin
    if (read_strobe) begin
      rq.push_back('{exp: (reset ? m_read(ms, port_id) : 8'h00),
                     has_c: cur_has_c, c: cur_c, pid: port_id});
    end
    rd_flag <= read_strobe;
    ms <= m_next(ms, reset, port_id, data_in, write_strobe, interrupt_ack, irq_src);
  end

  // Monitor: compare read data and the interrupt line mid-cycle
  always @(negedge clk) begin
    rd_t e;
    if (rd_flag) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL rd_queue: got read data %h with no expectation queued", data_out);
      end else begin
        e = rq.pop_front();
        if (data_out !== e.exp) begin
          bad++;
          $display("FAIL rd_model pid=%h: got %h want %h", e.pid, data_out, e.exp);
        end
        if (e.has_c) begin
          total++;
          if (data_out !== e.c) begin
            bad++;
            $display("FAIL rd_const pid=%h: got %h want %h", e.pid, data_out, e.c);
          end
        end
      end
    end
    total++;
    if (interrupt !== ms.intr) begin
      bad++;
      $display("FAIL irq_line t=%0t: got %b want %b", $time, interrupt, ms.intr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id = a; data_in = d; write_strobe = 1'b1;
    cyc();
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] c);
    port_id = a; read_strobe = 1'b1; cur_has_c = 1'b1; cur_c = c;
    cyc();
    read_strobe = 1'b0; cur_has_c = 1'b0;
  endtask

  task automatic ack_pulse();
    interrupt_ack = 1'b1;
    cyc();
    interrupt_ack = 1'b0;
  endtask

  task automatic chk_int(input logic exp, input string name);
    total++;
    if (interrupt !== exp) begin
      bad++;
      $display("FAIL int_%s: got %b want %b", name, interrupt, exp);
    end
  endtask

  initial begin
    reset = 1'b0; port_id = 8'h00; data_in = 8'h00; read_strobe = 1'b0;
    write_strobe = 1'b0; interrupt_ack = 1'b0; irq_src = '0;
    repeat (3) cyc();
    reset = 1'b1;
    chk_int(1'b0, "after_reset");

    // All offsets read zero after reset
    for (int o = 0; o < 16; o++) rd(8'h80 | 8'(o), 8'h00);
    chk_int(1'b0, "idle");

    // Level source 2 with ENABLE=0x05 and GIE
    wr(8'h86, 8'h00); wr(8'h82, 8'h05); wr(8'h89, 8'h01);
    irq_src = 12'h004;
    cyc(); cyc();
    chk_int(1'b1, "level_src2");
    rd(8'h88, 8'h82); rd(8'h80, 8'h04);
    irq_src = 12'h000;
    wr(8'h84, 8'h04);
    cyc();
    chk_int(1'b0, "w1c_src2");

    // Edge mode with auto-clear on ack
    wr(8'h86, 8'hFF); wr(8'h89, 8'h03); wr(8'h82, 8'hFF);
    irq_src = 12'h002; cyc(); irq_src = 12'h000; cyc();
    irq_src = 12'h040; cyc(); irq_src = 12'h000; cyc();
    rd(8'h84, 8'h42); rd(8'h88, 8'h81);
    ack_pulse();
    rd(8'h84, 8'h40); rd(8'h88, 8'h86);
    chk_int(1'b1, "before_2nd_ack");
    ack_pulse();
    rd(8'h88, 8'h00);
    chk_int(1'b0, "after_2nd_ack");

    // Edge set beats simultaneous W1C
    irq_src = 12'h008;
    wr(8'h84, 8'h08);
    irq_src = 12'h000;
    rd(8'h84, 8'h08);
    wr(8'h84, 8'h08);

    // Pending latches while masked
    wr(8'h86, 8'h00); wr(8'h82, 8'h00);
    irq_src = 12'h001; cyc();
    rd(8'h84, 8'h01); rd(8'h80, 8'h00);
    chk_int(1'b0, "masked");
    wr(8'h82, 8'h01);
    cyc();
    chk_int(1'b1, "unmasked");
    irq_src = 12'h000;
    wr(8'h84, 8'h01);

    // Upper sources, address decode, reset mid-interrupt
    wr(8'h83, 8'hFF); rd(8'h83, 8'h0F);
    irq_src = 12'h800; cyc();
    rd(8'h88, 8'h8B); rd(8'h70, 8'h00);
    cyc();
    chk_int(1'b1, "src11");
    reset = 1'b0; irq_src = 12'h000;
    cyc();
    chk_int(1'b0, "reset_mid");
    reset = 1'b1;
    rd(8'h84, 8'h00); rd(8'h85, 8'h00);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      irq_src       = 12'($urandom) & 12'($urandom);
      interrupt_ack = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          port_id = ($urandom_range(0, 9) == 0) ? (8'h70 | 8'($urandom_range(0, 15)))
                                                : (8'h80 | 8'($urandom_range(0, 15)));
          data_in = 8'($urandom);
          write_strobe = 1'b1;
        end
        3, 4, 5: begin
          port_id = ($urandom_range(0, 9) == 0) ? (8'h90 | 8'($urandom_range(0, 15)))
                                                : (8'h80 | 8'($urandom_range(0, 15)));
          read_strobe = 1'b1;
        end
        6: if ($urandom_range(0, 15) == 0) reset = 1'b0;
        default: ;
      endcase
      cyc();
      write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0; reset = 1'b1;
    end

    irq_src = '0;
    repeat (3) cyc();
    total++;
    if (rq.size() != 0) begin
      bad++;
      $display("FAIL rd_drain: got %0d entries left want 0", rq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
